// File: rtl/hazard_sequencer.sv
// Hazard and sequencing control for a 5-stage MIPS pipeline.
// Shadow scoreboard of EX/MEM/WB drives enables, flushes and forwarding.
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr,
  input  logic [4:0]       id_wdst,
  input  logic             id_load,
  input  logic             id_memop,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] dst;
    logic       load;
    logic       memop;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_t;

  sb_t ex_q, mem_q, wb_q;
  sb_t ex_d, mem_d, wb_d;
  sb_t id_e;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze, flush, lu_stall;
  logic ex_live, mem_live, wb_live;
  logic rs_hit, rt_hit;

  function automatic logic live(input sb_t e);
    return e.valid & e.wr & (e.dst != 5'd0);
  endfunction

  // Live writes exclude $0, so $0 can never match below.
  function automatic logic [1:0] fsel(
    input sb_t m,
    input sb_t w,
    input logic [4:0] r
  );
    if (live(m) && m.dst == r)
      return 2'b10;
    else if (live(w) && w.dst == r)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ex_live  = live(ex_q);
  assign mem_live = live(mem_q);
  assign wb_live  = live(wb_q);

  assign rs_hit = id_uses_rs & (id_rs == ex_q.dst);
  assign rt_hit = id_uses_rt & (id_rt == ex_q.dst);

  assign freeze = mem_q.valid & mem_q.memop
                & ~dmem_ready;
  assign flush  = ex_branch_taken & ~freeze & ~rst;
  assign lu_stall = ~freeze & ~flush & id_valid
                  & ex_live & ex_q.load
                  & (rs_hit | rt_hit);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      flush: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu_stall: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_q.valid) begin
      fwd_a = fsel(mem_q, wb_q, ex_q.rs);
      fwd_b = fsel(mem_q, wb_q, ex_q.rt);
    end
  end

  always_comb begin
    id_e.valid = id_valid;
    id_e.wr    = id_wr;
    id_e.dst   = id_wdst;
    id_e.load  = id_load;
    id_e.memop = id_memop;
    id_e.rs    = id_rs;
    id_e.rt    = id_rt;

    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = id_e;
      if (flush || lu_stall)
        ex_d = '0;
    end

    stall_d = stall_q;
    if (!pc_en && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);

    flush_d = flush_q;
    if (flush && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  logic unused_fields;
  assign unused_fields = ^{mem_q.load, wb_q.load,
                           wb_q.memop, wb_q.rs,
                           wb_q.rt, mem_q.rs,
                           mem_q.rt};

endmodule
